// File: rtl/fifo_rd_sched_pkg.sv
// Shared types and helpers for the FIFO read-side scheduler.
package fifo_rd_sched_pkg;

    // Scheduler FSM encoding.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SERVE = 1'b1
    } state_e;

    // Beat counter width; a grant never pops more than 255 words.
    localparam int BEAT_W = 8;

    // Value of the beat counter when the final word of a full burst is popped.
    function automatic logic [BEAT_W-1:0] beat_last(input int burst);
        return BEAT_W'(burst - 1);
    endfunction

endpackage

// File: rtl/fifo_rd_sched_rr_pick.sv
// Round-robin picker: first requesting channel at or above base, wrapping to 0.
// Rotates the request vector down by base, finds the lowest set bit, and adds
// base back so the index wraps naturally in CHW bits.
module fifo_rd_sched_rr_pick #(
    parameter int CHW = 2
) (
    input  logic [(1<<CHW)-1:0] req,
    input  logic [CHW-1:0]      base,
    output logic [CHW-1:0]      pick,
    output logic                any
);
    localparam int NCH = 1 << CHW;

    logic [2*NCH-1:0] dbl_s;
    logic [NCH-1:0]   rot_s;
    logic [CHW-1:0]   off_s;

    // Rotate, priority-encode the lowest set bit, then un-rotate.
    always_comb begin
        dbl_s = {req, req} >> base;
        rot_s = dbl_s[NCH-1:0];
        off_s = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? CHW'(i) : off_s;
        end
        pick = off_s + base;
        any  = |req;
    end

endmodule

// File: rtl/fifo_rd_sched.sv
// Read-side scheduler for a bank of FIFOs sharing one downstream consumer.
// Grants non-empty enabled channels round-robin, drains up to BURST words per
// grant and presents them on a registered valid/ready stream tagged by channel.
module fifo_rd_sched
    import fifo_rd_sched_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CHW   = 2,
    parameter int BURST = 4
) (
    input  logic                        rclk,
    input  logic                        rst_i,
    input  logic [(1<<CHW)-1:0]         cfg_en,
    input  logic [(1<<CHW)-1:0]         fifo_empty,
    input  logic [(1<<CHW)*WIDTH-1:0]   fifo_dat,
    output logic [(1<<CHW)-1:0]         fifo_ren,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [CHW-1:0]              out_ch,
    output logic                        out_last,
    output logic                        busy
);
    localparam int NCH = 1 << CHW;

    state_e              state_q, state_d;
    logic [CHW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CHW-1:0]      grant_q, grant_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [CHW-1:0]      out_ch_q, out_ch_d;
    logic                out_last_q, out_last_d;

    logic [NCH-1:0]      req_s;
    logic [CHW-1:0]      pick_s;
    logic                any_s;
    logic [WIDTH-1:0]    sel_dat_s;
    logic                pop_s;
    logic                at_last_s;
    logic                dry_s;

    assign req_s = cfg_en & ~fifo_empty;

    fifo_rd_sched_rr_pick #(.CHW(CHW)) u_pick (
        .req  (req_s),
        .base (rr_ptr_q),
        .pick (pick_s),
        .any  (any_s)
    );

    // Next-state, burst accounting and output register update.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;

        sel_dat_s = fifo_dat[grant_q*WIDTH +: WIDTH];
        at_last_s = (beat_cnt_q == beat_last(BURST));
        dry_s     = fifo_empty[grant_q] | ~cfg_en[grant_q];
        pop_s     = (state_q == S_SERVE) & ~fifo_empty[grant_q] & cfg_en[grant_q]
                  & (~out_valid_q | out_ready);

        case (state_q)
            S_IDLE: begin
                if (any_s) begin
                    grant_d    = pick_s;
                    beat_cnt_d = 8'd0;
                    state_d    = S_SERVE;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_SERVE: begin
                if (pop_s) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
                // Full burst or channel dried up / disabled; stalls alone never end a burst.
                if ((pop_s && at_last_s) || (!pop_s && dry_s)) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = grant_q + CHW'(1);
                end else begin
                    state_d  = S_SERVE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pop_s) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_dat_s;
            out_ch_d    = grant_q;
            out_last_d  = at_last_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
            out_last_d  = out_last_q;
        end
    end

    // Read strobe to the granted FIFO, same-edge as the output register load.
    always_comb begin
        fifo_ren = '0;
        if (pop_s && !rst_i) begin
            fifo_ren[grant_q] = 1'b1;
        end else begin
            fifo_ren = '0;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge rclk or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            beat_cnt_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == S_SERVE);

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Bench for fifo_rd_sched: directed vector table with driven flags, then
// multi-cycle sequences against a show-ahead FIFO model and a random stress run.
module tb_fifo_rd_sched;

    logic        rclk;
    logic        rst_i;
    logic [3:0]  cfg_en;
    logic [3:0]  fifo_empty_s;
    logic [15:0] fifo_dat_s;
    logic [3:0]  fifo_ren;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_last;
    logic        busy;

    logic        use_model;
    logic [3:0]  vec_empty;
    logic [15:0] vec_dat;
    logic [3:0]  mdl_empty;
    logic [15:0] mdl_dat;

    logic [3:0]  mem [4][256];
    int          wp [4] = '{0, 0, 0, 0};
    int          rp [4] = '{0, 0, 0, 0};
    logic [3:0]  sb [4][$];

    typedef struct packed {
        logic [1:0] ch;
        logic [3:0] d;
        logic       l;
    } ent_t;
    ent_t        log_q [$];
    int          log_t [$];
    ent_t        exp_q [$];

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          popcnt [4] = '{0, 0, 0, 0};
    int          viol_empty = 0;
    int          viol_bp = 0;
    int          viol_hot = 0;
    int          viol_hold = 0;
    logic        prev_stall = 1'b0;
    ent_t        prev_e;

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  emp;
        logic [15:0] dat;
        logic        rdy;
        logic [3:0]  ren;
        logic        v;
        logic [3:0]  d;
        logic [1:0]  ch;
        logic        l;
        logic        b;
    } vec_t;
    vec_t vt [13];

    assign fifo_empty_s = use_model ? mdl_empty : vec_empty;
    assign fifo_dat_s   = use_model ? mdl_dat   : vec_dat;

    fifo_rd_sched #(.WIDTH(4), .CHW(2), .BURST(4)) dut (
        .rclk       (rclk),
        .rst_i      (rst_i),
        .cfg_en     (cfg_en),
        .fifo_empty (fifo_empty_s),
        .fifo_dat   (fifo_dat_s),
        .fifo_ren   (fifo_ren),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_last   (out_last),
        .busy       (busy)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    // Show-ahead FIFO model: empty follows the registered read pointer.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mdl_empty[c]       = (rp[c] == wp[c]);
            mdl_dat[c*4 +: 4]  = mem[c][rp[c] % 256];
        end
    end

    // Read pointers advance on the strobed edge.
    always @(posedge rclk) begin
        for (int c = 0; c < 4; c++) begin
            if (use_model && fifo_ren[c]) rp[c] <= rp[c] + 1;
        end
    end

    // Monitor: log accepted words and track protocol violations.
    always @(posedge rclk) begin
        cyc <= cyc + 1;
        if (rst_i) begin
            prev_stall <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                log_q.push_back('{out_ch, out_data, out_last});
                log_t.push_back(cyc);
            end
            for (int c = 0; c < 4; c++) begin
                if (fifo_ren[c]) popcnt[c] <= popcnt[c] + 1;
            end
            if ((fifo_ren & fifo_empty_s) != 4'd0) viol_empty <= viol_empty + 1;
            if (fifo_ren != 4'd0 && out_valid && !out_ready) viol_bp <= viol_bp + 1;
            if ($countones(fifo_ren) > 1) viol_hot <= viol_hot + 1;
            if (prev_stall && (!out_valid || ent_t'({out_ch, out_data, out_last}) != prev_e))
                viol_hold <= viol_hold + 1;
            prev_stall <= out_valid & ~out_ready;
            prev_e     <= '{out_ch, out_data, out_last};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic push(input int c, input logic [3:0] v);
        mem[c][wp[c] % 256] = v;
        wp[c] = wp[c] + 1;
    endtask

    task automatic cmp_log(input string nm);
        chk({nm, "_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < log_q.size()) chk($sformatf("%s_w%0d", nm, i), 32'(log_q[i]), 32'(exp_q[i]));
        end
        exp_q.delete();
        log_q.delete();
        log_t.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int g;

        //            en     emp    dat       rdy   ren    v     d      ch     l     b
        vt[0]  = '{4'hF, 4'hF, 16'h0000, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
        vt[1]  = '{4'hF, 4'hD, 16'h0050, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1};
        vt[2]  = '{4'hF, 4'hD, 16'h0050, 1'b1, 4'h2, 1'b1, 4'h5, 2'd1, 1'b0, 1'b1};
        vt[3]  = '{4'hF, 4'hD, 16'h0060, 1'b1, 4'h2, 1'b1, 4'h6, 2'd1, 1'b0, 1'b1};
        vt[4]  = '{4'hF, 4'hD, 16'h0070, 1'b0, 4'h0, 1'b1, 4'h6, 2'd1, 1'b0, 1'b1};
        vt[5]  = '{4'hF, 4'hD, 16'h0070, 1'b1, 4'h2, 1'b1, 4'h7, 2'd1, 1'b0, 1'b1};
        vt[6]  = '{4'hF, 4'h5, 16'h0080, 1'b1, 4'h2, 1'b1, 4'h8, 2'd1, 1'b1, 1'b0};
        vt[7]  = '{4'hF, 4'h5, 16'h9080, 1'b1, 4'h0, 1'b0, 4'h8, 2'd1, 1'b0, 1'b1};
        vt[8]  = '{4'hF, 4'h5, 16'h9080, 1'b1, 4'h8, 1'b1, 4'h9, 2'd3, 1'b0, 1'b1};
        vt[9]  = '{4'hF, 4'hD, 16'h9080, 1'b1, 4'h0, 1'b0, 4'h9, 2'd3, 1'b0, 1'b0};
        vt[10] = '{4'hD, 4'hD, 16'h0000, 1'b1, 4'h0, 1'b0, 4'h9, 2'd3, 1'b0, 1'b0};
        vt[11] = '{4'hF, 4'hD, 16'h0000, 1'b1, 4'h0, 1'b0, 4'h9, 2'd3, 1'b0, 1'b1};
        vt[12] = '{4'hD, 4'hD, 16'h0000, 1'b1, 4'h0, 1'b0, 4'h9, 2'd3, 1'b0, 1'b0};

        rst_i = 1'b1; use_model = 1'b0; cfg_en = 4'hF; vec_empty = 4'hF;
        vec_dat = 16'h0000; out_ready = 1'b1;
        repeat (2) @(negedge rclk);
        chk("reset_out", {28'd0, out_valid, out_last, busy, |out_data}, 32'd0);
        chk("reset_ren_ch", {fifo_ren, 2'b00, out_ch}, 32'd0);
        rst_i = 1'b0;

        // Directed vectors with driven empty flags.
        for (int i = 0; i < 13; i++) begin
            @(negedge rclk);
            cfg_en = vt[i].en; vec_empty = vt[i].emp; vec_dat = vt[i].dat; out_ready = vt[i].rdy;
            #1 chk($sformatf("vec%0d_ren", i), fifo_ren, vt[i].ren);
            @(posedge rclk);
            #1 chk($sformatf("vec%0d_out", i), {out_valid, out_data, out_ch, out_last, busy},
                   {vt[i].v, vt[i].d, vt[i].ch, vt[i].l, vt[i].b});
        end

        @(negedge rclk);
        use_model = 1'b1; cfg_en = 4'hF; out_ready = 1'b1;
        repeat (3) @(negedge rclk);
        log_q.delete(); log_t.delete();

        // 1: six words on ch0 -> full burst, one idle cycle, short burst.
        for (int i = 0; i < 6; i++) push(0, 4'(i));
        repeat (20) @(negedge rclk);
        g = (log_t.size() >= 5) ? log_t[4] - log_t[3] : -1;
        chk("t1_idle_gap", g, 2);
        g = (log_t.size() >= 4) ? log_t[3] - log_t[0] : -1;
        chk("t1_burst_rate", g, 3);
        for (int i = 0; i < 6; i++) exp_q.push_back('{2'd0, 4'(i), (i == 3)});
        cmp_log("t1");

        // 2: ch1 and ch3 alternate in bursts of four.
        for (int i = 0; i < 8; i++) begin push(1, 4'(i)); push(3, 4'(i + 8)); end
        repeat (40) @(negedge rclk);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back('{(b % 2 == 0) ? 2'd1 : 2'd3,
                                  4'((b % 2 == 0 ? 0 : 8) + (b / 2) * 4 + i), (i == 3)});
            end
        end
        cmp_log("t2");

        // 3: ch2 under toggling back-pressure.
        push(2, 4'd3); push(2, 4'd6); push(2, 4'd9); push(2, 4'd12);
        for (int k = 0; k < 30; k++) begin
            @(negedge rclk);
            out_ready = (k % 4 == 0) || (k % 4 == 3);
        end
        out_ready = 1'b1;
        repeat (5) @(negedge rclk);
        exp_q.push_back('{2'd2, 4'd3, 1'b0}); exp_q.push_back('{2'd2, 4'd6, 1'b0});
        exp_q.push_back('{2'd2, 4'd9, 1'b0}); exp_q.push_back('{2'd2, 4'd12, 1'b1});
        cmp_log("t3");

        // 4: ch0 disabled after its second pop.
        base = popcnt[0];
        for (int i = 0; i < 6; i++) push(0, 4'(10 + i));
        for (int k = 0; k < 20 && popcnt[0] - base < 2; k++) @(negedge rclk);
        cfg_en = 4'hE;
        chk("t4_pops_before_disable", popcnt[0] - base, 2);
        repeat (10) @(negedge rclk);
        chk("t4_busy", busy, 1'b0);
        chk("t4_left_in_fifo", wp[0] - rp[0], 4);
        chk("t4_rr_ptr", dut.rr_ptr_q, 2'd1);
        exp_q.push_back('{2'd0, 4'd10, 1'b0}); exp_q.push_back('{2'd0, 4'd11, 1'b0});
        cmp_log("t4");

        // 5: asynchronous reset mid-burst, then grant restarts from channel 0.
        base = popcnt[3];
        for (int i = 0; i < 4; i++) push(3, 4'(i + 1));
        for (int k = 0; k < 20 && popcnt[3] - base < 2; k++) @(negedge rclk);
        chk("t5_pops_before_reset", popcnt[3] - base, 2);
        #3 rst_i = 1'b1; cfg_en = 4'hF;
        #1 chk("t5_reset_now", {busy, out_valid, fifo_ren}, 6'd0);
        log_q.delete(); log_t.delete();
        #12 rst_i = 1'b0;
        repeat (20) @(negedge rclk);
        exp_q.push_back('{2'd0, 4'd12, 1'b0}); exp_q.push_back('{2'd0, 4'd13, 1'b0});
        exp_q.push_back('{2'd0, 4'd14, 1'b0}); exp_q.push_back('{2'd0, 4'd15, 1'b1});
        exp_q.push_back('{2'd3, 4'd3, 1'b0});  exp_q.push_back('{2'd3, 4'd4, 1'b0});
        cmp_log("t5");

        // 6: random writes from a slower clock, random back-pressure.
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    int c;
                    logic [3:0] v;
                    #14;
                    if ($time % 5 == 0) #1;
                    c = $urandom_range(3);
                    v = 4'($urandom_range(15));
                    push(c, v);
                    sb[c].push_back(v);
                end
            end
            begin
                for (int k = 0; k < 70; k++) begin
                    @(negedge rclk);
                    out_ready = ($urandom_range(3) != 0);
                end
            end
        join
        @(negedge rclk);
        out_ready = 1'b1;
        repeat (60) @(negedge rclk);
        chk("t6_count", log_q.size(), 40);
        for (int i = 0; i < log_q.size(); i++) begin
            if (sb[log_q[i].ch].size() == 0) begin
                chk($sformatf("t6_dup_ch%0d", log_q[i].ch), 1, 0);
            end else begin
                chk($sformatf("t6_order_%0d", i), log_q[i].d, sb[log_q[i].ch].pop_front());
            end
        end
        chk("t6_leftover", sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size(), 0);

        chk("ren_to_empty", viol_empty, 0);
        chk("ren_while_stalled", viol_bp, 0);
        chk("ren_onehot", viol_hot, 0);
        chk("hold_while_stalled", viol_hold, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
